// File: rtl/life_ctrl.sv
// life_ctrl: game-state controller for the pacman top level.
// Detects pacman/ghost contact once per frame, counts lives, runs the death
// freeze, and declares win or game over until the restart key is pressed.
// Optional build macro LIFE_CTRL_EXTRA_LIFE_EN adds a one-per-game extra life
// once dots_left falls to EXTRA_LIFE_DOTS or below.
module life_ctrl #(
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned HIT_DIST     = 8,
    parameter logic [7:0]  RESTART_KEY  = 8'h28,
    parameter int unsigned NUM_GHOSTS   = 4
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
    ,
    parameter int unsigned EXTRA_LIFE_DOTS = 16
`endif
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_clk,
    input  logic [9:0]              pX,
    input  logic [9:0]              pY,
    input  logic [10*NUM_GHOSTS-1:0] gX,
    input  logic [10*NUM_GHOSTS-1:0] gY,
    input  logic [31:0]             dots_left,
    input  logic [7:0]              keycode,
    output logic                    lifeDown,
    output logic                    restart,
    output logic                    freeze,
    output logic [2:0]              lives,
    output logic                    game_over,
    output logic                    win
);

    typedef enum logic [1:0] {PLAY, DYING, OVER, WIN} state_t;

    localparam logic [9:0] HIT_DIST_10 = 10'(HIT_DIST);
    localparam logic [7:0] DEATH_CNT   = 8'(DEATH_FRAMES);
    localparam logic [2:0] START_CNT   = 3'(START_LIVES);

    state_t      state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        life_down_q, life_down_d;
    logic        restart_q, restart_d;
    logic        freeze_q, over_q, win_q;
    logic        frame_sync_p0, frame_sync_p1, frame_dly_p2;
    logic [7:0]  keycode_q;
    logic        tick, key_hit, hit;
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
    logic        extra_q, extra_d;
    logic        award;
`endif

    // Larger minus smaller keeps the distance free of modular wrap.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [2:0] lives_dec(input logic [2:0] l);
        return (l == 3'd0) ? 3'd0 : l - 3'd1;
    endfunction

`ifdef LIFE_CTRL_EXTRA_LIFE_EN
    function automatic logic [2:0] lives_inc(input logic [2:0] l);
        return (l == 3'd7) ? 3'd7 : l + 3'd1;
    endfunction
`endif

    // Frame strobe synchroniser plus delay flop for rising-edge detection; keycode history.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync_p0 <= 1'b0;
            frame_sync_p1 <= 1'b0;
            frame_dly_p2  <= 1'b0;
            keycode_q     <= 8'd0;
        end else begin
            frame_sync_p0 <= frame_clk;
            frame_sync_p1 <= frame_sync_p0;
            frame_dly_p2  <= frame_sync_p1;
            keycode_q     <= keycode;
        end
    end

    assign tick    = frame_sync_p1 & ~frame_dly_p2;
    assign key_hit = (keycode == RESTART_KEY) && (keycode_q != RESTART_KEY);

    // Contact test: any ghost within HIT_DIST on both axes.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_GHOSTS); i++) begin
            if ((abs_diff(pX, gX[10*i +: 10]) <= HIT_DIST_10) &&
                (abs_diff(pY, gY[10*i +: 10]) <= HIT_DIST_10))
                hit = 1'b1;
        end
    end

    // Game FSM next-state, lives and freeze-counter logic.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        life_down_d = 1'b0;
        restart_d   = 1'b0;
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
        extra_d     = extra_q;
        award       = 1'b0;
`endif
        case (state_q)
            PLAY: begin
                if (tick) begin
                    if (dots_left == 32'd0) begin
                        state_d = WIN;
                    end else begin
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
                        award = !extra_q && (dots_left <= EXTRA_LIFE_DOTS);
                        if (award)
                            extra_d = 1'b1;
                        // An award and a hit on the same tick cancel out.
                        if (award && !hit)
                            lives_d = lives_inc(lives_q);
                        else if (!award && hit)
                            lives_d = lives_dec(lives_q);
`else
                        if (hit)
                            lives_d = lives_dec(lives_q);
`endif
                        if (hit) begin
                            life_down_d = 1'b1;
                            cnt_d       = DEATH_CNT;
                            state_d     = DYING;
                        end
                    end
                end
            end
            DYING: begin
                if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1)
                        state_d = (lives_q == 3'd0) ? OVER : PLAY;
                end
            end
            OVER, WIN: begin
                if (key_hit) begin
                    restart_d = 1'b1;
                    lives_d   = START_CNT;
                    cnt_d     = 8'd0;
                    state_d   = PLAY;
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
                    extra_d   = 1'b0;
`endif
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= PLAY;
            lives_q     <= START_CNT;
            cnt_q       <= 8'd0;
            life_down_q <= 1'b0;
            restart_q   <= 1'b0;
            freeze_q    <= 1'b0;
            over_q      <= 1'b0;
            win_q       <= 1'b0;
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
            extra_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            life_down_q <= life_down_d;
            restart_q   <= restart_d;
            freeze_q    <= (state_d != PLAY);
            over_q      <= (state_d == OVER);
            win_q       <= (state_d == WIN);
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
            extra_q     <= extra_d;
`endif
        end
    end

    assign lifeDown  = life_down_q;
    assign restart   = restart_q;
    assign freeze    = freeze_q;
    assign lives     = lives_q;
    assign game_over = over_q;
    assign win       = win_q;

endmodule

// File: doc/life_ctrl.md
Name: life_ctrl

Overview:
- Game-state controller that drives the `lifeDown` and `restart` inputs consumed by the ghost and pacman sprite modules.
- Detects pacman/ghost contact once per frame, counts lives, and runs the death-freeze interval.
- Declares win or game-over, then re-arms the game from a keyboard restart key.
- Sits beside the sprite and dot modules in the top level, clocked by the 50 MHz system clock.

Parameters:
- START_LIVES, 3: lives loaded at reset and on restart (range 1..7).
- DEATH_FRAMES, 60: frame ticks spent frozen after a hit (range 1..255).
- HIT_DIST, 8: maximum per-axis centre distance, in pixels, that counts as contact.
- RESTART_KEY, 8'h28: keycode that restarts the game (Enter).
- NUM_GHOSTS, 4: number of ghost position inputs checked.

Ports:
- Clk, input, 1: system clock, 50 MHz.
- Reset_n, input, 1: asynchronous, active-low reset.
- frame_clk, input, 1: vertical-sync-rate strobe, asynchronous level; rising edge = frame tick.
- pX, input, 10: pacman centre X.
- pY, input, 10: pacman centre Y.
- gX, input, 10*NUM_GHOSTS: ghost centre X values, packed; ghost i occupies bits [10i+9:10i].
- gY, input, 10*NUM_GHOSTS: ghost centre Y values, packed in the same way.
- dots_left, input, 32: remaining dot count from the dot module.
- keycode, input, 8: current keyboard keycode.
- lifeDown, output, 1: one-Clk pulse on a pacman death.
- restart, output, 1: one-Clk pulse on a game restart.
- freeze, output, 1: high while sprites must hold position.
- lives, output, 3: lives remaining.
- game_over, output, 1: high in the OVER state.
- win, output, 1: high in the WIN state.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state = PLAY, lives = START_LIVES, frame counter = 0.
  - lifeDown, restart, freeze, game_over and win all 0.
  - Resetting mid-DYING aborts the freeze immediately.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then one more register.
  - tick = synchronised & ~delayed: a single Clk cycle, about 3 cycles after the edge.
- Key edge:
  - keycode is registered once.
  - key_hit = (keycode == RESTART_KEY) && (keycode_q != RESTART_KEY), so a held key fires only once.
- Contact:
  - hit_i = |pX − gX_i| <= HIT_DIST && |pY − gY_i| <= HIT_DIST.
  - Use unsigned 10-bit subtraction, larger minus smaller, so no wrap.
  - hit = OR over all ghosts.
  - Evaluated only on tick.
- State PLAY (freeze = 0):
  - On tick with dots_left == 0 → WIN. Win has priority over hit on the same tick.
  - Else on tick with hit:
    - lifeDown = 1 for the next cycle only.
    - lives decrements, saturating at 0.
    - Frame counter loads DEATH_FRAMES; → DYING.
  - key_hit is ignored in PLAY.
- State DYING (freeze = 1):
  - Each tick decrements the counter.
  - When a tick finds the counter == 1: lives == 0 → OVER, else → PLAY.
  - Further hits are ignored; key_hit is ignored.
- State OVER (game_over = 1, freeze = 1) and state WIN (win = 1, freeze = 1):
  - On key_hit: restart = 1 for exactly one cycle, lives = START_LIVES, → PLAY.
  - game_over and win drop in the same cycle restart rises.
- Latency:
  - lifeDown is registered, high in the cycle after the tick cycle.
  - restart is high in the cycle after the key_hit cycle.
  - lifeDown and restart are never high together.
- Outputs are all registered; no combinational paths from inputs to outputs.

Optional Feature:
- Macro: LIFE_CTRL_EXTRA_LIFE_EN.
- When defined:
  - Adds parameter EXTRA_LIFE_DOTS (default 16).
  - The first PLAY tick with dots_left <= EXTRA_LIFE_DOTS increments lives, saturating at 7.
  - Awarded once per game; the flag is cleared by reset and by restart.
  - If the same tick is also a hit, lives is net unchanged and the flag is still set.
- When undefined: no extra-life logic and no flag register; lives only decrements or reloads.

Test Plan:
- Reset with Reset_n=0, release → lives=3, all pulses 0, freeze=0; contact held with no frame_clk edge → lifeDown stays 0.
- Ghost 0 at (100,50), pacman at (105,54), one frame_clk edge → single lifeDown pulse, lives=2, freeze=1; after 60 more ticks freeze=0 and state is PLAY.
- Three successive hits with DEATH_FRAMES=2 → lives 2,1,0, then game_over=1; keycode=8'h28 held 100 cycles → exactly one restart pulse, lives=3, game_over=0.
- Pacman at (100,50) and ghost at (109,50) → no hit; ghost at (108,50) → hit; pacman X=3, ghost X=1010 → no hit, confirming no wrap.
- dots_left=0 and contact on the same tick → win=1, no lifeDown, lives unchanged.
- With LIFE_CTRL_EXTRA_LIFE_EN defined: dots_left steps 20 → 16 → 10 → lives 3 → 4 → 4; Reset_n pulsed mid-DYING → PLAY, lives=3.
